// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, parameter limits
// and a small helper for sizing counters.
package rst_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_SYNC = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } rst_state_e;

  localparam int NUM_STAGES_MIN  = 1;
  localparam int NUM_STAGES_MAX  = 16;
  localparam int SYNC_STAGES_MIN = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES
// rising clock edges with rstn held high.
module reset_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  output logic rstn_sync
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("reset_sync_chain: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rstn_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_seq.sv
// Domain reset sequencer: synchronises the board reset, then releases
// NUM_STAGES domain resets in index order, with a software re-reset handshake.
module reset_release_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic                  rstn_sync,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  rst_done
);

  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_num_stages
    $error("reset_release_seq: NUM_STAGES out of range");
  end
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
    $error("reset_release_seq: HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_STAGES) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  rst_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  done_q;
  logic                  ack_q;
  logic                  sync_rstn;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .rstn_sync(sync_rstn)
  );

  // The edge where the synchroniser releases is E0 itself, so the first
  // WAIT_SYNC cycle that sees it high already counts as hold cycle 0.
  logic             hold_tick;
  logic [CNT_W-1:0] hold_cnt;

  assign hold_tick = (state_q == HOLD) || ((state_q == WAIT_SYNC) && sync_rstn);
  assign hold_cnt  = (state_q == HOLD) ? cnt_q : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        WAIT_SYNC, HOLD: begin
          if (hold_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              stage_q <= NUM_STAGES'(1);
              cnt_q   <= '0;
              idx_q   <= IDX_W'(1);
              if (NUM_STAGES == 1) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              cnt_q   <= hold_cnt + 1'b1;
              state_q <= HOLD;
            end
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            stage_q <= stage_q | (NUM_STAGES'(1) << idx_q);
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Accepting a soft request makes this edge the new E0.
          if (soft_req) begin
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= HOLD;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign soft_ack   = ack_q;
  assign rstn_sync  = sync_rstn;
  assign stage_rstn = stage_q;
  assign rst_done   = done_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Directed bench for reset_release_seq: power-up timing table, async glitch,
// soft re-reset handshake, mid-sequence reset and a minimal configuration.
module tb_reset_release_seq;

  logic       clk;
  logic       rstn;
  logic       soft_req;
  logic       soft_ack;
  logic       rstn_sync;
  logic [3:0] stage_rstn;
  logic       rst_done;

  logic       rstn_b;
  logic       soft_req_b;
  logic       soft_ack_b;
  logic       rstn_sync_b;
  logic [0:0] stage_rstn_b;
  logic       rst_done_b;

  int total = 0;
  int bad   = 0;

  reset_release_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .soft_req  (soft_req),
    .soft_ack  (soft_ack),
    .rstn_sync (rstn_sync),
    .stage_rstn(stage_rstn),
    .rst_done  (rst_done)
  );

  reset_release_seq #(
    .SYNC_STAGES(3),
    .NUM_STAGES (1),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (4)
  ) dut_min (
    .clk       (clk),
    .rstn      (rstn_b),
    .soft_req  (soft_req_b),
    .soft_ack  (soft_ack_b),
    .rstn_sync (rstn_sync_b),
    .stage_rstn(stage_rstn_b),
    .rst_done  (rst_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       sync;
    logic [3:0] stg;
    logic       done;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_sync"}, 32'(rstn_sync), 32'd0);
    check({nm, "_stg"},  32'(stage_rstn), 32'd0);
    check({nm, "_done"}, 32'(rst_done), 32'd0);
    check({nm, "_ack"},  32'(soft_ack), 32'd0);
  endtask

  // Assert rstn for 5 cycles, then release it midway between edges.
  task automatic do_reset();
    rstn = 1'b0;
    repeat (5) tick();
    check_all_zero("rst");
    #4 rstn = 1'b1;
  endtask

  // Walk the power-up table; edge 1 is the first rising edge after release.
  task automatic apply_table(input string nm);
    int n = 0;
    for (int i = 0; i < 11; i++) begin
      while (n < tbl[i].n) begin
        tick();
        n++;
      end
      check({nm, "_sync"}, 32'(rstn_sync), 32'(tbl[i].sync));
      check({nm, "_stg"},  32'(stage_rstn), 32'(tbl[i].stg));
      check({nm, "_done"}, 32'(rst_done), 32'(tbl[i].done));
      check({nm, "_ack"},  32'(soft_ack), 32'd0);
    end
  endtask

  function automatic logic [3:0] exp_stg(input int j);
    logic [3:0] s;
    for (int k = 0; k < 4; k++) s[k] = (j >= 16 + 4 * k);
    return s;
  endfunction

  // Called just after sampling edge E0 of a soft re-reset.
  task automatic seq_from_e0(input string nm);
    for (int j = 1; j <= 28; j++) begin
      tick();
      check({nm, "_stg"},  32'(stage_rstn), 32'(exp_stg(j)));
      check({nm, "_done"}, 32'(rst_done), 32'(j >= 28));
      check({nm, "_ack"},  32'(soft_ack), 32'd0);
      check({nm, "_sync"}, 32'(rstn_sync), 32'd1);
    end
  endtask

  initial begin
    tbl[0]  = '{n: 1,  sync: 1'b0, stg: 4'b0000, done: 1'b0};
    tbl[1]  = '{n: 2,  sync: 1'b1, stg: 4'b0000, done: 1'b0};
    tbl[2]  = '{n: 17, sync: 1'b1, stg: 4'b0000, done: 1'b0};
    tbl[3]  = '{n: 18, sync: 1'b1, stg: 4'b0001, done: 1'b0};
    tbl[4]  = '{n: 21, sync: 1'b1, stg: 4'b0001, done: 1'b0};
    tbl[5]  = '{n: 22, sync: 1'b1, stg: 4'b0011, done: 1'b0};
    tbl[6]  = '{n: 25, sync: 1'b1, stg: 4'b0011, done: 1'b0};
    tbl[7]  = '{n: 26, sync: 1'b1, stg: 4'b0111, done: 1'b0};
    tbl[8]  = '{n: 29, sync: 1'b1, stg: 4'b0111, done: 1'b0};
    tbl[9]  = '{n: 30, sync: 1'b1, stg: 4'b1111, done: 1'b1};
    tbl[10] = '{n: 31, sync: 1'b1, stg: 4'b1111, done: 1'b1};

    rstn       = 1'b0;
    soft_req   = 1'b0;
    rstn_b     = 1'b0;
    soft_req_b = 1'b0;

    // Power-up sequence
    do_reset();
    apply_table("pwr");

    // Sub-period glitch while in DONE
    #1 rstn = 1'b0;
    #2 check_all_zero("glitch");
    #3 rstn = 1'b1;
    apply_table("glitch_seq");

    // Soft re-reset from DONE
    soft_req = 1'b1;
    tick();
    check("soft_e0_stg",  32'(stage_rstn), 32'd0);
    check("soft_e0_done", 32'(rst_done), 32'd0);
    check("soft_e0_ack",  32'(soft_ack), 32'd1);
    check("soft_e0_sync", 32'(rstn_sync), 32'd1);
    soft_req = 1'b0;
    seq_from_e0("soft");

    // Soft request raised during HOLD stays pending until DONE
    do_reset();
    repeat (5) tick();
    soft_req = 1'b1;
    for (int n = 6; n <= 30; n++) begin
      tick();
      check("pend_ack", 32'(soft_ack), 32'd0);
    end
    check("pend_done", 32'(rst_done), 32'd1);
    tick();
    check("pend_e0_ack",  32'(soft_ack), 32'd1);
    check("pend_e0_stg",  32'(stage_rstn), 32'd0);
    check("pend_e0_done", 32'(rst_done), 32'd0);
    soft_req = 1'b0;
    seq_from_e0("pend");

    // Reset asserted mid-release
    do_reset();
    repeat (22) tick();
    check("mid_pre_stg", 32'(stage_rstn), 32'b0011);
    #1 rstn = 1'b0;
    #1 check_all_zero("mid");
    #3 rstn = 1'b1;
    apply_table("mid_seq");

    // Minimal configuration: SYNC_STAGES=3, NUM_STAGES=1, HOLD_CYCLES=1
    check("min_rst_sync", 32'(rstn_sync_b), 32'd0);
    check("min_rst_stg",  32'(stage_rstn_b), 32'd0);
    check("min_rst_done", 32'(rst_done_b), 32'd0);
    #4 rstn_b = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check("min_sync", 32'(rstn_sync_b), 32'(n >= 3));
      check("min_stg",  32'(stage_rstn_b), 32'(n >= 4));
      check("min_done", 32'(rst_done_b), 32'(n >= 4));
      check("min_ack",  32'(soft_ack_b), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
